mem_arbiter: RTL and testbench

Two-client memory arbiter downstream of the instruction cache and data cache. It merges icache fetch requests and dcache load/store requests onto the single RAM port. It returns per-client wait/load handshakes to each cache. The arbiter serves one transaction at a time. Grants are registered, and fairness is enforced when both clients contend.

---
 rtl/cpu_types_pkg.sv | 19 +
 rtl/mem_arbiter.sv | 116 +++++++++++
 tb/tb_mem_arbiter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM handshake state, machine word, and the arbiter grant state.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISERV = 2'd1,
    DSERV = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-client (icache/dcache) arbiter onto one RAM port; one transaction at a time,
// registered grant, alternation on contention, sticky error flag.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter word_t ERR_WORD = 32'hBAD1BAD1
) (
  input  logic      CLK,
  input  logic      RST,
  input  logic      iREN,
  input  word_t     iaddr,
  output logic      iwait,
  output word_t     iload,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      dwait,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  output logic      err
);

  arb_state_t state_q, state_d;
  logic       last_d_q, last_d_d;
  logic       err_q, err_d;

  logic  dreq, ram_done, ram_err;
  word_t ret_word;

  assign dreq     = dREN | dWEN;
  assign ram_err  = (ramstate == ERROR);
  assign ram_done = (ramstate == ACCESS) | ram_err;
  assign ret_word = ram_err ? ERR_WORD : ramload;
  assign err      = err_q;

  // Withdrawal wins over completion: a client that dropped its request owns no result.
  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (dreq && (!iREN || !last_d_q)) state_d = DSERV;
        else if (iREN)                    state_d = ISERV;
      end
      ISERV: begin
        if (!iREN) state_d = IDLE;
        else if (ram_done) begin
          state_d  = IDLE;
          last_d_d = 1'b0;
          err_d    = err_q | ram_err;
        end
      end
      DSERV: begin
        if (!dreq) state_d = IDLE;
        else if (ram_done) begin
          state_d  = IDLE;
          last_d_d = 1'b1;
          err_d    = err_q | ram_err;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    case (state_q)
      ISERV: begin
        ramaddr = iaddr;
        ramREN  = iREN;
        if (iREN && ram_done) begin
          iwait = 1'b0;
          iload = ret_word;
        end
      end
      DSERV: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        if (dreq && ram_done) begin
          dwait = 1'b0;
          dload = ret_word;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      last_d_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed cycle table for the spec scenarios, then randomized traffic against a transaction-level model.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  logic      CLK, RST, iREN, dREN, dWEN, iwait, dwait, ramREN, ramWEN, err;
  word_t     iaddr, iload, daddr, dstore, dload, ramaddr, ramstore, ramload;
  ramstate_t ramstate;

  mem_arbiter #(.ERR_WORD(32'hBAD1BAD1)) dut (
    .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .err(err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic      rst, ir, dr, dw;
    word_t     ia, da, ds;
    ramstate_t rs;
    word_t     rl;
    logic      ck;
    logic      e_iw, e_dw, e_ren, e_wen;
    word_t     e_addr, e_il, e_dl;
    logic      e_err;
  } vec_t;

  function automatic vec_t row(logic rst, logic ir, logic dr, logic dw, word_t ia, word_t da,
                               word_t ds, ramstate_t rs, word_t rl, logic ck, logic e_iw,
                               logic e_dw, logic e_ren, logic e_wen, word_t e_addr,
                               word_t e_il, word_t e_dl, logic e_err);
    vec_t v;
    v.rst = rst; v.ir = ir; v.dr = dr; v.dw = dw; v.ia = ia; v.da = da; v.ds = ds;
    v.rs = rs; v.rl = rl; v.ck = ck; v.e_iw = e_iw; v.e_dw = e_dw; v.e_ren = e_ren;
    v.e_wen = e_wen; v.e_addr = e_addr; v.e_il = e_il; v.e_dl = e_dl; v.e_err = e_err;
    return v;
  endfunction

  vec_t tbl[$];

  task automatic drive(input logic rst, input logic ir, input logic dr, input logic dw,
                       input word_t ia, input word_t da, input word_t ds,
                       input ramstate_t rs, input word_t rl);
    RST = rst; iREN = ir; dREN = dr; dWEN = dw; iaddr = ia; daddr = da; dstore = ds;
    ramstate = rs; ramload = rl;
  endtask

  // Transaction-level reference: who owns the port, who was served last, sticky error.
  typedef enum int {NONE, ICL, DCL} owner_t;
  owner_t m_own;
  bit     m_lastd, m_err;

  task automatic model_cycle(input string tag);
    bit    req, fin;
    word_t ret;
    logic  e_iw, e_dw, e_ren, e_wen;
    word_t e_addr, e_il, e_dl;
    req = (m_own == ICL) ? iREN : (m_own == DCL) ? (dREN | dWEN) : 1'b0;
    fin = req && (ramstate == ACCESS || ramstate == ERROR);
    ret = (ramstate == ERROR) ? 32'hBAD1BAD1 : ramload;
    e_iw = 1; e_dw = 1; e_il = 0; e_dl = 0; e_ren = 0; e_wen = 0; e_addr = 0;
    if (m_own == ICL) begin
      e_addr = iaddr; e_ren = iREN;
      if (fin) begin e_iw = 0; e_il = ret; end
    end else if (m_own == DCL) begin
      e_addr = daddr; e_wen = dWEN; e_ren = dREN && !dWEN;
      if (fin) begin e_dw = 0; e_dl = ret; end
      if (dWEN) chk({tag, " ramstore"}, ramstore, dstore);
    end
    chk({tag, " iwait"}, iwait, e_iw);
    chk({tag, " dwait"}, dwait, e_dw);
    chk({tag, " iload"}, iload, e_il);
    chk({tag, " dload"}, dload, e_dl);
    chk({tag, " ramREN"}, ramREN, e_ren);
    chk({tag, " ramWEN"}, ramWEN, e_wen);
    chk({tag, " ramaddr"}, ramaddr, e_addr);
    chk({tag, " err"}, err, m_err);
    if (RST) begin
      m_own = NONE; m_lastd = 0; m_err = 0;
    end else if (m_own == NONE) begin
      if ((dREN || dWEN) && iREN) m_own = m_lastd ? ICL : DCL;
      else if (dREN || dWEN)      m_own = DCL;
      else if (iREN)              m_own = ICL;
    end else if (!req) begin
      m_own = NONE;
    end else if (fin) begin
      m_lastd = (m_own == DCL);
      if (ramstate == ERROR) m_err = 1;
      m_own = NONE;
    end
  endtask

  initial begin
    drive(1, 1, 0, 0, 0, 0, 0, FREE, 0);
    // rst ir dr dw  iaddr daddr dstore  rs  ramload  ck iw dw ren wen addr iload dload err
    tbl.push_back(row(1,1,0,0, 32'h40,0,0, FREE, 0,            0, 1,1,0,0, 0,0,0,0));
    tbl.push_back(row(1,1,0,0, 32'h40,0,0, FREE, 0,            1, 1,1,0,0, 0,0,0,0));
    tbl.push_back(row(0,1,0,0, 32'h40,0,0, FREE, 0,            1, 1,1,0,0, 0,0,0,0));
    tbl.push_back(row(0,1,0,0, 32'h40,0,0, ACCESS, 32'h8C010004, 1, 0,1,1,0, 32'h40,32'h8C010004,0,0));
    tbl.push_back(row(0,0,0,0, 0,0,0, FREE, 0,                 1, 1,1,0,0, 0,0,0,0));
    // contention, last_d=0: d, i, d
    tbl.push_back(row(0,1,1,0, 32'h200,32'h300,0, FREE, 0,     1, 1,1,0,0, 0,0,0,0));
    tbl.push_back(row(0,1,1,0, 32'h200,32'h300,0, ACCESS, 32'h11111111, 1, 1,0,1,0, 32'h300,0,32'h11111111,0));
    tbl.push_back(row(0,1,1,0, 32'h200,32'h300,0, FREE, 0,     1, 1,1,0,0, 0,0,0,0));
    tbl.push_back(row(0,1,1,0, 32'h200,32'h300,0, ACCESS, 32'h22222222, 1, 0,1,1,0, 32'h200,32'h22222222,0,0));
    tbl.push_back(row(0,1,1,0, 32'h200,32'h300,0, FREE, 0,     1, 1,1,0,0, 0,0,0,0));
    tbl.push_back(row(0,1,1,0, 32'h200,32'h300,0, ACCESS, 32'h33333333, 1, 1,0,1,0, 32'h300,0,32'h33333333,0));
    // store with 3 BUSY cycles
    tbl.push_back(row(0,0,1,1, 0,32'h100,32'hDEADBEEF, FREE, 0, 1, 1,1,0,0, 0,0,0,0));
    for (int k = 0; k < 3; k++)
      tbl.push_back(row(0,0,1,1, 0,32'h100,32'hDEADBEEF, BUSY, 0, 1, 1,1,0,1, 32'h100,0,0,0));
    tbl.push_back(row(0,0,1,1, 0,32'h100,32'hDEADBEEF, ACCESS, 32'h44444444, 1, 1,0,0,1, 32'h100,0,32'h44444444,0));
    // RAM error on a fetch
    tbl.push_back(row(0,1,0,0, 32'h80,0,0, FREE, 0,            1, 1,1,0,0, 0,0,0,0));
    tbl.push_back(row(0,1,0,0, 32'h80,0,0, ERROR, 32'h55555555, 1, 0,1,1,0, 32'h80,32'hBAD1BAD1,0,0));
    tbl.push_back(row(0,0,0,0, 0,0,0, FREE, 0,                 1, 1,1,0,0, 0,0,0,1));
    // withdrawal during BUSY; last_d stays 0 so dcache wins the next tie
    tbl.push_back(row(0,0,1,0, 0,32'h500,0, FREE, 0,           1, 1,1,0,0, 0,0,0,1));
    tbl.push_back(row(0,0,1,0, 0,32'h500,0, BUSY, 0,           1, 1,1,1,0, 32'h500,0,0,1));
    tbl.push_back(row(0,0,0,0, 0,32'h500,0, BUSY, 0,           1, 1,1,0,0, 32'h500,0,0,1));
    tbl.push_back(row(0,1,1,0, 32'h600,32'h700,0, FREE, 0,     1, 1,1,0,0, 0,0,0,1));
    tbl.push_back(row(0,1,1,0, 32'h600,32'h700,0, BUSY, 0,     1, 1,1,1,0, 32'h700,0,0,1));
    // reset mid-DSERV
    tbl.push_back(row(1,1,1,0, 32'h600,32'h700,0, BUSY, 0,     0, 1,1,0,0, 0,0,0,0));
    tbl.push_back(row(0,0,0,0, 0,0,0, FREE, 0,                 1, 1,1,0,0, 0,0,0,0));

    for (int r = 0; r < tbl.size(); r++) begin
      string t;
      t = $sformatf("row%0d", r);
      @(negedge CLK);
      drive(tbl[r].rst, tbl[r].ir, tbl[r].dr, tbl[r].dw, tbl[r].ia, tbl[r].da, tbl[r].ds,
            tbl[r].rs, tbl[r].rl);
      #1;
      if (tbl[r].ck) begin
        chk({t, " iwait"}, iwait, tbl[r].e_iw);
        chk({t, " dwait"}, dwait, tbl[r].e_dw);
        chk({t, " ramREN"}, ramREN, tbl[r].e_ren);
        chk({t, " ramWEN"}, ramWEN, tbl[r].e_wen);
        chk({t, " ramaddr"}, ramaddr, tbl[r].e_addr);
        chk({t, " iload"}, iload, tbl[r].e_il);
        chk({t, " dload"}, dload, tbl[r].e_dl);
        chk({t, " err"}, err, tbl[r].e_err);
        if (tbl[r].e_wen) chk({t, " ramstore"}, ramstore, tbl[r].ds);
      end
    end

    // randomized phase; first cycle is a reset so the model starts aligned
    m_own = NONE; m_lastd = 0; m_err = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge CLK);
      drive((c == 0) || ($urandom_range(0, 99) == 0),
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 255) << 2, $urandom_range(0, 255) << 2, $urandom,
            ramstate_t'($urandom_range(0, 3)), $urandom);
      #1;
      model_cycle($sformatf("rnd%0d", c));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
